// File: rtl/fx3_packet_sender.sv
// fx3_packet_sender: reads one full packet at a time from the sample FIFO and
// streams it to the FX3 slave FIFO. The SLWR# strobe is derived from readData
// delayed by the FIFO/converter read latency, so strobes line up with data.
module fx3_packet_sender #(
  parameter int PACKET_WORDS = 8192,  // words per USB packet, >= 2
  parameter int READ_LATENCY = 2,     // readData -> valid fifoData, >= 1
  parameter int GAP_CYCLES   = 2      // idle cycles after each packet, >= 1
) (
  input  logic        fx3_clock,
  input  logic        reset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic        fx3_ready,
  input  logic [15:0] fifoData,
  output logic        readData,
  output logic [15:0] dataOut,
  output logic        fx3_nWrite,
  output logic        busy,
  output logic [15:0] packetCount
);

  // One counter is shared by the burst, drain and gap phases, so it is sized
  // for the longest of them.
  localparam int CW = $clog2(PACKET_WORDS + READ_LATENCY + GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WORD  = CW'(PACKET_WORDS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(READ_LATENCY);
  localparam logic [CW-1:0] LAST_GAP   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               read_reg, read_next;
  logic               busy_reg, busy_next;
  logic [15:0]        packet_count_reg, packet_count_next;
  logic [READ_LATENCY-1:0] valid_pipe;
  logic [15:0]        data_reg;
  logic               nwrite_reg;

  // Control registers: state, phase counter and registered control outputs.
  always_ff @(posedge fx3_clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      read_reg         <= 1'b0;
      busy_reg         <= 1'b0;
      packet_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      read_reg         <= read_next;
      busy_reg         <= busy_next;
      packet_count_reg <= packet_count_next;
    end
  end

  // Next-state logic; inputs are only looked at in IDLE, so a started packet
  // always runs to completion.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    read_next         = 1'b0;
    packet_count_next = packet_count_reg;
    case (state_reg)
      IDLE: begin
        if (collectData && dataAvailable && fx3_ready) begin
          state_next = STREAM;
          read_next  = 1'b1;
          cnt_next   = '0;
        end
      end
      STREAM: begin
        if (cnt_reg == LAST_WORD) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          read_next = 1'b1;
          cnt_next  = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        // The last strobe cycle ends on the edge that leaves DRAIN.
        if (cnt_reg == LAST_DRAIN) begin
          state_next        = GAP;
          cnt_next          = '0;
          packet_count_next = packet_count_reg + 16'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == LAST_GAP) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // Valid pipeline: readData delayed READ_LATENCY cycles marks fifoData valid.
  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_valid
      if (gi == 0) begin : g_first
        // First stage samples the read request itself.
        always_ff @(posedge fx3_clock or posedge reset) begin
          if (reset) valid_pipe[gi] <= 1'b0;
          else       valid_pipe[gi] <= read_reg;
        end
      end else begin : g_rest
        // Later stages simply shift the valid flag along.
        always_ff @(posedge fx3_clock or posedge reset) begin
          if (reset) valid_pipe[gi] <= 1'b0;
          else       valid_pipe[gi] <= valid_pipe[gi-1];
        end
      end
    end
  endgenerate

  // FX3 bus register: data always follows fifoData, strobe follows valid.
  always_ff @(posedge fx3_clock or posedge reset) begin
    if (reset) begin
      data_reg   <= '0;
      nwrite_reg <= 1'b1;
    end else begin
      data_reg   <= fifoData;
      nwrite_reg <= ~valid_pipe[READ_LATENCY-1];
    end
  end

  assign readData    = read_reg;
  assign dataOut     = data_reg;
  assign fx3_nWrite  = nwrite_reg;
  assign busy        = busy_reg;
  assign packetCount = packet_count_reg;

endmodule

// File: tb/tb_fx3_packet_sender.sv
// Directed bench for fx3_packet_sender with a small FIFO read-latency model.
module tb_fx3_packet_sender;
  localparam int PW = 16;
  localparam int RL = 2;
  localparam int GC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        collectData = 1'b0;
  logic        dataAvailable = 1'b0;
  logic        fx3_ready = 1'b0;
  logic [15:0] fifoData = 16'h0;
  logic [15:0] d1 = 16'h0;
  logic        readData;
  logic [15:0] dataOut;
  logic        fx3_nWrite;
  logic        busy;
  logic [15:0] packetCount;
  int          rd_idx = 0;
  int          checks = 0;
  int          errors = 0;

  fx3_packet_sender #(
    .PACKET_WORDS(PW),
    .READ_LATENCY(RL),
    .GAP_CYCLES  (GC)
  ) dut (
    .fx3_clock    (clk),
    .reset        (reset),
    .collectData  (collectData),
    .dataAvailable(dataAvailable),
    .fx3_ready    (fx3_ready),
    .fifoData     (fifoData),
    .readData     (readData),
    .dataOut      (dataOut),
    .fx3_nWrite   (fx3_nWrite),
    .busy         (busy),
    .packetCount  (packetCount)
  );

  always #5 clk = ~clk;

  // FIFO path model: n-th read returns 0x1000+n, two cycles after the request.
  always @(posedge clk) begin
    if (readData) begin
      d1     <= 16'(32'h1000 + rd_idx);
      rd_idx <= rd_idx + 1;
    end
    fifoData <= d1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for readData to go high; the sample where it is seen is offset 0.
  task automatic wait_start(input int limit, input string tag);
    int n = 0;
    while (readData !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(readData), 32'd1);
  endtask

  // Check one whole packet cycle by cycle from offset 0 to the return to IDLE.
  task automatic run_packet(input int drop_at, input logic [15:0] exp_count);
    int          base;
    logic [15:0] w;
    base = rd_idx;
    for (int i = 0; i <= PW + RL + 1 + GC; i++) begin
      if (i > 0) @(negedge clk);
      check_eq($sformatf("rd[%0d]", i), 32'(readData), 32'(i < PW));
      check_eq($sformatf("nwr[%0d]", i), 32'(fx3_nWrite),
               32'(!(i >= RL + 1 && i <= PW + RL)));
      if (i >= RL + 1 && i <= PW + RL) begin
        w = 16'(32'h1000 + base + i - RL - 1);
        check_eq($sformatf("data[%0d]", i), 32'(dataOut), 32'(w));
      end
      check_eq($sformatf("busy[%0d]", i), 32'(busy), 32'(i < PW + RL + 1 + GC));
      if (i == drop_at) collectData = 1'b0;
    end
    check_eq("pkt_count", 32'(packetCount), 32'(exp_count));
  endtask

  // Count readData-high cycles over a window where no packet may start.
  task automatic expect_no_reads(input int cycles, input string tag);
    int highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (readData) highs++;
    end
    check_eq(tag, 32'(highs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_rd", 32'(readData), 32'd0);
    check_eq("rst_nwr", 32'(fx3_nWrite), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cnt", 32'(packetCount), 32'd0);
    check_eq("rst_data", 32'(dataOut), 32'd0);
    reset = 1'b0;
    expect_no_reads(3, "idle_no_enable");

    // Single packet.
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1;
    wait_start(5, "start1");
    run_packet(1, 16'd1);
    expect_no_reads(20, "idle_after1");

    // collectData drops at word 5: packet still completes, no new one.
    collectData = 1'b1;
    wait_start(5, "start2");
    run_packet(5, 16'd2);
    expect_no_reads(30, "idle_after_stop");
    check_eq("busy_after_stop", 32'(busy), 32'd0);

    // Flow control: no FX3 space means no reads.
    collectData = 1'b1; fx3_ready = 1'b0;
    expect_no_reads(100, "flow_hold");
    fx3_ready = 1'b1;
    wait_start(1, "flow_start");
    run_packet(-1, 16'd3);

    // Back-to-back: next start exactly one cycle after IDLE is reached (22 cycles).
    wait_start(1, "b2b_start");
    run_packet(1, 16'd4);
    expect_no_reads(5, "idle_after_b2b");

    // Wrap of the packet counter.
    force dut.packet_count_reg = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.packet_count_reg;
    @(negedge clk);
    check_eq("preload", 32'(packetCount), 32'hFFFF);
    collectData = 1'b1;
    wait_start(5, "wrap_start");
    run_packet(1, 16'd0);

    // Asynchronous reset in the middle of a burst (word 7).
    collectData = 1'b1;
    wait_start(5, "rst_start");
    repeat (7) @(negedge clk);
    check_eq("pre_rst_rd", 32'(readData), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("async_rd", 32'(readData), 32'd0);
    check_eq("async_nwr", 32'(fx3_nWrite), 32'd1);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_cnt", 32'(packetCount), 32'd0);
    collectData = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    expect_no_reads(10, "idle_after_rst");
    check_eq("nwr_after_rst", 32'(fx3_nWrite), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx3_packet_sender.md
Name: fx3_packet_sender

Overview:
- FX3-side consumer of the sample FIFO.
- Waits until a full packet is buffered and the FX3 slave FIFO can accept it, then burst-reads PACKET_WORDS words from the FIFO.
- Drives the FX3 data bus and active-low write strobe, aligned to the FIFO/converter read latency.
- Counts completed packets. Sits between the data generator's FIFO read port and the FX3 GPIF pins, all on fx3_clock.

Parameters:
- PACKET_WORDS, 8192: words per USB packet; 14-bit counter at default; must be ≥ 2.
- READ_LATENCY, 2: cycles from readData high to the matching valid word on fifoData (FIFO q + 10→16-bit converter register); must be ≥ 1.
- GAP_CYCLES, 2: idle cycles after each packet so the FX3 flag can update; must be ≥ 1.

Ports:
- fx3_clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- collectData, input, 1: capture enabled; new packets start only while high.
- dataAvailable, input, 1: FIFO holds at least PACKET_WORDS words.
- fx3_ready, input, 1: FX3 slave FIFO watermark flag; high means space for one full packet.
- fifoData, input, 16: converted sample word from the FIFO path.
- readData, output, 1: FIFO read request, one word per cycle.
- dataOut, output, 16: FX3 data bus.
- fx3_nWrite, output, 1: FX3 SLWR#, active low.
- busy, output, 1: high in any state other than IDLE.
- packetCount, output, 16: completed packets, wraps at 65535→0.

Behaviour:
- Reset (async, any state, mid-packet included): state=IDLE, readData=0, fx3_nWrite=1, dataOut=0, busy=0, packetCount=0, word counter=0, valid pipeline cleared. No partial-packet recovery; words already read are discarded.
- All outputs are registered.
- IDLE: if collectData && dataAvailable && fx3_ready at a rising edge, go to STREAM; readData goes high from that same edge.
- STREAM:
  - readData=1 for exactly PACKET_WORDS consecutive cycles; the word counter counts 0..PACKET_WORDS-1.
  - Then readData=0 and the state goes to DRAIN.
  - Inputs are ignored during the burst: collectData falling, dataAvailable falling or fx3_ready falling never truncates or pauses a packet.
- Valid pipeline:
  - readData is delayed READ_LATENCY cycles to mark fifoData valid.
  - On each edge: dataOut <= fifoData; fx3_nWrite <= !valid.
  - So fx3_nWrite is low for exactly PACKET_WORDS contiguous cycles, starting READ_LATENCY+1 cycles after the first readData-high cycle.
  - Word k on dataOut equals the k-th word read.
- dataOut also tracks fifoData when not writing. Its value is don't-care while fx3_nWrite=1.
- DRAIN: lasts READ_LATENCY+1 cycles until the last strobe completes. Increment packetCount in the cycle the last fx3_nWrite-low cycle ends. Then go to GAP.
- GAP: lasts GAP_CYCLES cycles with readData=0 and fx3_nWrite=1. Then go to IDLE.
- IDLE re-evaluates the start condition on its first cycle. Back-to-back packets therefore have a minimum spacing of PACKET_WORDS+READ_LATENCY+1+GAP_CYCLES+1 cycles between readData rising edges.
- dataAvailable high with fx3_ready low: remain in IDLE indefinitely with no reads. FIFO overflow is reported by the generator's bufferError, not here.
- collectData low in IDLE: no new packet. A packet in flight always completes.
- packetCount is not cleared by collectData; only reset clears it.

Test Plan:
- Reset: assert reset mid-STREAM (PACKET_WORDS=16, word 7) -> readData=0, fx3_nWrite=1, busy=0, packetCount=0 asynchronously, before the next edge.
- Single packet (PACKET_WORDS=16, READ_LATENCY=2), fifoData model returns 0x1000+n for the n-th read -> readData high 16 cycles from edge E; fx3_nWrite low cycles E+3..E+18; dataOut=0x1000..0x100F in order; packetCount=1; busy low at E+16+3+2.
- Flow control: dataAvailable=1, collectData=1, fx3_ready=0 for 100 cycles -> readData never asserts. fx3_ready rises -> burst starts next edge.
- Stop mid-packet: collectData falls at word 5 of 16 -> all 16 reads and 16 strobes still occur, packetCount increments, state returns to IDLE with no further packet.
- Back-to-back: all inputs held high (PACKET_WORDS=16, GAP_CYCLES=2) -> second readData rise exactly 16+3+2+1=22 cycles after the first; no strobe gaps within either packet.
- Wrap: preload 65535 packets (or force the counter) and complete one more -> packetCount=0.
